matrix_keyscan_encoder: RTL and testbench

Parametrised successor to the fixed 4x3 numpad scanner plus LED encoder. Scans an ROWS x COLS matrix keypad, debounces whole scan frames and encodes a single pressed key as a binary code. Emits press/release strobes and a multi-key flag. Sits between the SB_IO row inputs (pull-ups, active-low) and the board logic (LEDs, later a UART/command path).

---
 rtl/matrix_keyscan_encoder_if.sv | 24 ++
 rtl/matrix_keyscan_encoder.sv | 184 ++++++++++++++++++
 tb/tb_matrix_keyscan_encoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_keyscan_encoder_if.sv
// rtl/matrix_keyscan_encoder_if.sv - keypad pins and debounced key event outputs of the matrix scanner
interface matrix_keyscan_encoder_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 3,
    parameter int CODE_W = 4
);
    logic [ROWS-1:0]   keypad_row;
    logic [COLS-1:0]   keypad_col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_press;
    logic              key_release;
    logic              multi_key;

    modport master (
        input  keypad_row,
        output keypad_col, key_code, key_valid, key_press, key_release, multi_key
    );

    modport slave (
        output keypad_row,
        input  keypad_col, key_code, key_valid, key_press, key_release, multi_key
    );
endinterface

// File: rtl/matrix_keyscan_encoder.sv
// rtl/matrix_keyscan_encoder.sv - ROWSxCOLS keypad scanner, frame debouncer and single-key encoder
// Optional auto-repeat of key_press is built when KEYSCAN_AUTOREPEAT_EN is defined.
module matrix_keyscan_encoder #(
    parameter int ROWS         = 4,
    parameter int COLS         = 3,
    parameter int SCAN_DIV     = 3333,
    parameter int DEBOUNCE     = 4,
    parameter int CODE_W       = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input logic                      clk_3p33MHz,
    input logic                      rst,
    matrix_keyscan_encoder_if.master kp
);
    localparam int N  = ROWS * COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(DEBOUNCE + 1);

    if ((2 ** CODE_W) <= N) begin : g_code_w_check
        $error("CODE_W cannot encode every key of the matrix");
    end
    if (SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("matrix_keyscan_encoder parameter out of range");
    end

    logic [DW-1:0]     dwell_cnt;
    logic [CW-1:0]     col_idx;
    logic [COLS-1:0]   col_sel;
    logic [N-1:0]      frame_cur;
    logic [N-1:0]      frame_new;
    logic [N-1:0]      frame_prev;
    logic [SW-1:0]     stable_cnt;
    logic [SW-1:0]     stable_next;
    logic              accept_pend;
    logic              sample;
    logic              frame_done;
    logic [1:0]        pop_sat;
    logic [CODE_W-1:0] hit_code;
    logic [CODE_W-1:0] new_code;
    logic              new_valid;
    logic              new_multi;
    logic              code_change;
    logic              rep_fire;
    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q;
    logic              key_press_q;
    logic              key_release_q;
    logic              multi_key_q;

    assign sample     = (dwell_cnt == DW'(SCAN_DIV - 1));
    assign frame_done = sample && (col_idx == CW'(COLS - 1));

    always_comb begin
        col_sel = '0;
        for (int c = 0; c < COLS; c++) begin
            col_sel[c] = (col_idx == CW'(c));
        end
    end

    // Frame bit r*COLS+c holds the closure of row r on column c.
    always_comb begin
        frame_new = frame_cur;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (col_idx == CW'(c)) begin
                    frame_new[r*COLS + c] = ~kp.keypad_row[r];
                end
            end
        end
    end

    always_comb begin
        stable_next = SW'(1);
        if (frame_new == frame_prev) begin
            stable_next = (stable_cnt == SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_3p33MHz) begin
        if (rst) begin
            dwell_cnt   <= '0;
            col_idx     <= '0;
            frame_cur   <= '0;
            frame_prev  <= '0;
            stable_cnt  <= '0;
            accept_pend <= 1'b0;
        end else begin
            accept_pend <= 1'b0;
            if (sample) begin
                dwell_cnt <= '0;
                frame_cur <= frame_new;
                if (frame_done) begin
                    col_idx     <= '0;
                    frame_prev  <= frame_new;
                    stable_cnt  <= stable_next;
                    accept_pend <= (stable_next == SW'(DEBOUNCE));
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    // frame_prev holds the accepted frame for the whole cycle accept_pend is high.
    always_comb begin
        pop_sat  = 2'd0;
        hit_code = '0;
        for (int i = 0; i < N; i++) begin
            if (frame_prev[i]) begin
                hit_code = CODE_W'(i + 1);
                if (pop_sat != 2'd2) begin
                    pop_sat = pop_sat + 2'd1;
                end
            end
        end
        new_valid = (pop_sat == 2'd1);
        new_multi = (pop_sat == 2'd2);
        new_code  = new_valid ? hit_code : '0;
    end

    assign code_change = (new_code != key_code_q);

`ifdef KEYSCAN_AUTOREPEAT_EN
    localparam int RW = 16;
    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic          same_key;
    logic [RW-1:0] rep_target;

    assign same_key   = new_valid && key_valid_q && !code_change;
    assign rep_target = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
    assign rep_fire   = accept_pend && same_key && ((rep_cnt + 1'b1) >= rep_target);

    always_ff @(posedge clk_3p33MHz) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (accept_pend) begin
            if (!same_key) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk_3p33MHz) begin
        if (rst) begin
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            multi_key_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
            if (accept_pend) begin
                key_code_q    <= new_code;
                key_valid_q   <= new_valid;
                multi_key_q   <= new_multi;
                key_press_q   <= new_valid && (code_change || rep_fire);
                key_release_q <= key_valid_q && code_change;
            end
        end
    end

    assign kp.keypad_col  = col_sel;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_press   = key_press_q;
    assign kp.key_release = key_release_q;
    assign kp.multi_key   = multi_key_q;
endmodule

// File: tb/tb_matrix_keyscan_encoder.sv
// tb/tb_matrix_keyscan_encoder.sv - table-driven bench with frame-level scoreboard for matrix_keyscan_encoder
module tb_matrix_keyscan_encoder;
    localparam int ROWS         = 4;
    localparam int COLS         = 3;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE     = 3;
    localparam int CODE_W       = 4;
    localparam int REPEAT_DELAY = 2;
    localparam int REPEAT_RATE  = 1;
    localparam int N            = ROWS * COLS;
    localparam int FRAME        = COLS * SCAN_DIV;

    typedef struct {
        int         cyc;
        logic [3:0] code;
        logic       valid;
        logic       multi;
        logic       press;
        logic       rel;
    } ev_t;

    typedef struct {
        logic [N-1:0] keys;
        int           frames;
        logic [3:0]   code;
        logic         valid;
        logic         multi;
    } step_t;

    logic clk_3p33MHz = 1'b0;
    logic rst         = 1'b1;
    always #5 clk_3p33MHz = ~clk_3p33MHz;

    matrix_keyscan_encoder_if #(.ROWS(ROWS), .COLS(COLS), .CODE_W(CODE_W)) kif ();

    matrix_keyscan_encoder #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
        .CODE_W(CODE_W), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) dut (
        .clk_3p33MHz(clk_3p33MHz),
        .rst        (rst),
        .kp         (kif)
    );

    // Keypad model: a closed key pulls its row low while its column is selected.
    logic [N-1:0]    keys = '0;
    logic [ROWS-1:0] row_drv;
    always_comb begin
        row_drv = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (keys[r*COLS + c] && kif.keypad_col[c]) row_drv[r] = 1'b0;
            end
        end
    end
    assign kif.keypad_row = row_drv;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    ev_t   sbq[$];
    step_t steps[14];

    logic [N-1:0] m_prev;
    int           m_stable;
    logic [3:0]   m_code;
    logic         m_valid;
    logic         m_multi;
`ifdef KEYSCAN_AUTOREPEAT_EN
    int           m_rep;
    bit           m_first;
`endif

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_3p33MHz);
        if (!rst) cyc++;
    endtask

    task automatic model_reset();
        m_prev   = '0;
        m_stable = 0;
        m_code   = 4'd0;
        m_valid  = 1'b0;
        m_multi  = 1'b0;
`ifdef KEYSCAN_AUTOREPEAT_EN
        m_rep    = 0;
        m_first  = 1'b1;
`endif
    endtask

    // Called right after the edge that completes a frame; predicts the encode update one cycle later.
    task automatic model_frame();
        int         pop;
        logic [3:0] nc;
        logic       nv, nm, pr, rl;
        ev_t        e;
        if (keys == m_prev) begin
            if (m_stable < DEBOUNCE) m_stable++;
        end else begin
            m_stable = 1;
        end
        m_prev = keys;
        if (m_stable == DEBOUNCE) begin
            pop = $countones(keys);
            nv  = (pop == 1);
            nm  = (pop >= 2);
            nc  = 4'd0;
            if (nv) begin
                for (int i = 0; i < N; i++) if (keys[i]) nc = 4'(i + 1);
            end
            pr = nv && (nc != m_code);
            rl = m_valid && (nc != m_code);
`ifdef KEYSCAN_AUTOREPEAT_EN
            if (nv && m_valid && nc == m_code) begin
                m_rep++;
                if (m_rep >= (m_first ? REPEAT_DELAY : REPEAT_RATE)) begin
                    pr      = 1'b1;
                    m_rep   = 0;
                    m_first = 1'b0;
                end
            end else begin
                m_rep   = 0;
                m_first = 1'b1;
            end
`endif
            if (pr || rl || nc != m_code || nv != m_valid || nm != m_multi) begin
                e = '{cyc + 1, nc, nv, nm, pr, rl};
                sbq.push_back(e);
            end
            m_code  = nc;
            m_valid = nv;
            m_multi = nm;
        end
    endtask

    task automatic check_step(input int idx);
        chk($sformatf("step%0d_code", idx), int'(kif.key_code), int'(steps[idx].code));
        chk($sformatf("step%0d_valid", idx), int'(kif.key_valid), int'(steps[idx].valid));
        chk($sformatf("step%0d_multi", idx), int'(kif.multi_key), int'(steps[idx].multi));
    endtask

    task automatic frame(input bit check_prev, input int idx);
        if (check_prev) begin
            tick();
            @(negedge clk_3p33MHz);
            check_step(idx);
            repeat (FRAME - 1) tick();
        end else begin
            repeat (FRAME) tick();
        end
        model_frame();
    endtask

    // Scoreboard monitor: any strobe or output change must match the next predicted event.
    initial begin
        ev_t        e;
        logic [3:0] o_code  = 4'd0;
        logic       o_valid = 1'b0;
        logic       o_multi = 1'b0;
        forever begin
            @(negedge clk_3p33MHz);
            if (kif.key_press || kif.key_release || kif.key_code !== o_code ||
                kif.key_valid !== o_valid || kif.multi_key !== o_multi) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected cyc=%0d code=%0d valid=%0d multi=%0d press=%0d release=%0d required=no event",
                             cyc, kif.key_code, kif.key_valid, kif.multi_key, kif.key_press, kif.key_release);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_cycle", cyc, e.cyc);
                    chk("sb_code", int'(kif.key_code), int'(e.code));
                    chk("sb_valid", int'(kif.key_valid), int'(e.valid));
                    chk("sb_multi", int'(kif.multi_key), int'(e.multi));
                    chk("sb_press", int'(kif.key_press), int'(e.press));
                    chk("sb_release", int'(kif.key_release), int'(e.rel));
                end
                o_code  = kif.key_code;
                o_valid = kif.key_valid;
                o_multi = kif.multi_key;
            end
        end
    end

    initial begin
        ev_t e;
        steps[0]  = '{12'h000, 2, 4'd0,  1'b0, 1'b0};
        steps[1]  = '{12'h080, 5, 4'd8,  1'b1, 1'b0};
        steps[2]  = '{12'h000, 4, 4'd0,  1'b0, 1'b0};
        steps[3]  = '{12'h001, 1, 4'd0,  1'b0, 1'b0};
        steps[4]  = '{12'h000, 1, 4'd0,  1'b0, 1'b0};
        steps[5]  = '{12'h001, 1, 4'd0,  1'b0, 1'b0};
        steps[6]  = '{12'h000, 1, 4'd0,  1'b0, 1'b0};
        steps[7]  = '{12'h001, 1, 4'd0,  1'b0, 1'b0};
        steps[8]  = '{12'h000, 1, 4'd0,  1'b0, 1'b0};
        steps[9]  = '{12'h001, 3, 4'd1,  1'b1, 1'b0};
        steps[10] = '{12'h011, 4, 4'd0,  1'b0, 1'b1};
        steps[11] = '{12'h001, 4, 4'd1,  1'b1, 1'b0};
        steps[12] = '{12'h800, 6, 4'd12, 1'b1, 1'b0};
        steps[13] = '{12'h000, 4, 4'd0,  1'b0, 1'b0};
        model_reset();

        tick();
        tick();
        @(negedge clk_3p33MHz);
        chk("reset_col", int'(kif.keypad_col), 1);
        chk("reset_code", int'(kif.key_code), 0);
        chk("reset_valid", int'(kif.key_valid), 0);
        chk("reset_press", int'(kif.key_press), 0);
        chk("reset_release", int'(kif.key_release), 0);
        chk("reset_multi", int'(kif.multi_key), 0);
        rst = 1'b0;

        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) begin
                tick();
                @(negedge clk_3p33MHz);
            end
            chk($sformatf("col_step%0d", c), int'(kif.keypad_col), 1 << ((c / SCAN_DIV) % COLS));
        end
        tick();
        model_frame();

        for (int i = 0; i < 14; i++) begin
            #1 keys = steps[i].keys;
            for (int f = 0; f < steps[i].frames; f++) begin
                frame(i > 0 && f == 0, i - 1);
            end
        end
        tick();
        @(negedge clk_3p33MHz);
        check_step(13);
        repeat (FRAME - 1) tick();
        model_frame();

        // Reset in the middle of a frame while key 5 is valid.
        #1 keys = 12'h010;
        for (int f = 0; f < DEBOUNCE; f++) frame(1'b0, 0);
        tick();
        @(negedge clk_3p33MHz);
        chk("abort_pre_code", int'(kif.key_code), 5);
        chk("abort_pre_valid", int'(kif.key_valid), 1);
        repeat (5) tick();
        #1 rst = 1'b1;
        model_reset();
        e = '{cyc, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        sbq.push_back(e);
        tick();
        @(negedge clk_3p33MHz);
        chk("abort_col", int'(kif.keypad_col), 1);
        chk("abort_code", int'(kif.key_code), 0);
        chk("abort_valid", int'(kif.key_valid), 0);
        rst = 1'b0;

        for (int f = 0; f < DEBOUNCE; f++) frame(1'b0, 0);
        tick();
        @(negedge clk_3p33MHz);
        chk("post_reset_code", int'(kif.key_code), 5);
        repeat (FRAME - 1) tick();
        model_frame();
        #1 keys = '0;
        for (int f = 0; f < 4; f++) frame(1'b0, 0);
        tick();
        @(negedge clk_3p33MHz);
        chk("final_valid", int'(kif.key_valid), 0);
        chk("final_code", int'(kif.key_code), 0);
        repeat (2 * FRAME) tick();
        @(negedge clk_3p33MHz);
        chk("sb_pending", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
